// File: rtl/seq_divider.sv
`default_nettype none
//============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider. Divides a
//               DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor and
//               resolves one quotient bit per clock, MSB first, under a
//               start/busy/done handshake.
//
// Ports       : clk          rising-edge clock
//               rst          synchronous active-high reset
//               start        request, sampled only in IDLE or DONE
//               dividend     unsigned dividend, captured on accepted start
//               divisor      unsigned divisor, captured on accepted start
//               busy         high while iterating (RUN)
//               done         one-cycle pulse, results valid
//               quotient     result, held until the next completion
//               remainder    result, held until the next completion
//               div_by_zero  set with done when the captured divisor was 0
//
// Options     : DIVIDER_DIV0_FAST_EN - when defined, a zero divisor seen at
//               the accepting edge skips RUN and completes immediately.
//
// Revision    : 1.0 - initial release
//============================================================================
module seq_divider #(
    parameter int DIVIDEND_W = 4,
    parameter int DIVISOR_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int c_CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DIVIDEND_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_count;
    logic [DIVIDEND_W-1:0] r_dvd;       // captured dividend, shifted left each step
    logic [DIVISOR_W-1:0]  r_dvs;       // captured divisor
    logic [DIVISOR_W:0]    r_prem;      // partial remainder, one guard bit
    logic [DIVIDEND_W-1:0] r_quot;      // quotient being assembled
    logic                  r_busy;
    logic                  r_done;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div0;

    // One restoring step. The partial remainder is always below the divisor
    // before the shift, so after the shift it fits in DIVISOR_W+1 bits.
    logic [DIVISOR_W:0]    w_shift;
    logic                  w_ge;
    logic [DIVISOR_W:0]    w_prem_next;
    logic [DIVIDEND_W-1:0] w_quot_next;

    always_comb begin
        w_shift     = {r_prem[DIVISOR_W-1:0], r_dvd[DIVIDEND_W-1]};
        w_ge        = (w_shift >= {1'b0, r_dvs});
        w_prem_next = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
        w_quot_next = {r_quot[DIVIDEND_W-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_quot      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div0      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_prem  <= '0;
                        r_quot  <= '0;
                        r_count <= c_CNT_LOAD;
`ifdef DIVIDER_DIV0_FAST_EN
                        if (divisor == '0) begin
                            // Nothing to iterate: publish the div-by-zero
                            // result straight away.
                            r_state     <= c_DONE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_div0      <= 1'b1;
                        end else begin
                            r_state <= c_RUN;
                            r_busy  <= 1'b1;
                        end
`else
                        r_state <= c_RUN;
                        r_busy  <= 1'b1;
`endif
                    end else begin
                        r_state <= c_IDLE;
                    end
                end

                c_RUN: begin
                    r_dvd   <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
                    r_prem  <= w_prem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count - c_CNT_ONE;
                    if (r_count == c_CNT_ONE) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_dvs == '0) begin
                            // Iterations against zero yield garbage
                            // remainder bits; force the defined result.
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_div0      <= 1'b1;
                        end else begin
                            r_quotient  <= w_quot_next;
                            r_remainder <= w_prem_next[DIVISOR_W-1:0];
                            r_div0      <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
//============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider at default widths
//               (4-bit dividend, 2-bit divisor). Table vectors, hand-written
//               handshake sequences and random operations, all checked
//               against plain arithmetic division.
// Revision    : 1.0 - initial release
//============================================================================
module tb_seq_divider;

    localparam int DW = 4;
    localparam int SW = 2;
`ifdef DIVIDER_DIV0_FAST_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [SW-1:0] b;
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          z;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain unsigned division with the div-by-zero convention.
    task automatic model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << DW) - 1;
            r = 0;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endtask

    // Present operands with start for one edge; returns #1 after that edge.
    task automatic start_op(input int a, input int b);
        dividend = DW'(a);
        divisor  = SW'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done and busy samples on the way; bounded.
    task automatic wait_done(input string tag, output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no done expected done within 20 cycles", tag);
        end
    endtask

    // Full operation: start, wait, compare results, latency and done pulse.
    task automatic run_op(input string tag, input int a, input int b,
                          input int eq, input int er, input int ez);
        int edges, bc, exp_lat;
        start_op(a, b);
        wait_done(tag, edges, bc);
        exp_lat = (c_FAST && b == 0) ? 0 : DW;
        check({tag, "_q"}, int'(quotient), eq);
        check({tag, "_r"}, int'(remainder), er);
        check({tag, "_z"}, int'(div_by_zero), ez);
        check({tag, "_lat"}, edges, exp_lat);
        check({tag, "_busycyc"}, bc, exp_lat);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_q_hold"}, int'(quotient), eq);
    endtask

    vec_t vecs[12];

    initial begin
        int eq, er, ez, edges, bc;

        vecs[0]  = '{a: 4'd9,  b: 2'd3, q: 4'd3,  r: 2'd0, z: 1'b0};
        vecs[1]  = '{a: 4'd9,  b: 2'd2, q: 4'd4,  r: 2'd1, z: 1'b0};
        vecs[2]  = '{a: 4'd15, b: 2'd1, q: 4'd15, r: 2'd0, z: 1'b0};
        vecs[3]  = '{a: 4'd0,  b: 2'd3, q: 4'd0,  r: 2'd0, z: 1'b0};
        vecs[4]  = '{a: 4'd6,  b: 2'd0, q: 4'd15, r: 2'd0, z: 1'b1};
        vecs[5]  = '{a: 4'd6,  b: 2'd3, q: 4'd2,  r: 2'd0, z: 1'b0};
        vecs[6]  = '{a: 4'd14, b: 2'd3, q: 4'd4,  r: 2'd2, z: 1'b0};
        vecs[7]  = '{a: 4'd7,  b: 2'd2, q: 4'd3,  r: 2'd1, z: 1'b0};
        vecs[8]  = '{a: 4'd15, b: 2'd3, q: 4'd5,  r: 2'd0, z: 1'b0};
        vecs[9]  = '{a: 4'd1,  b: 2'd2, q: 4'd0,  r: 2'd1, z: 1'b0};
        vecs[10] = '{a: 4'd0,  b: 2'd0, q: 4'd15, r: 2'd0, z: 1'b1};
        vecs[11] = '{a: 4'd15, b: 2'd2, q: 4'd7,  r: 2'd1, z: 1'b0};

        // Reset held with start asserted.
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_z", int'(div_by_zero), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy), 0);

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), int'(vecs[i].a), int'(vecs[i].b),
                   int'(vecs[i].q), int'(vecs[i].r), int'(vecs[i].z));
        end

        // Div-by-zero flag clears on the next nonzero-divisor completion.
        run_op("div0", 6, 0, 15, 0, 1);
        run_op("after_div0", 6, 3, 2, 0, 0);

        // In-flight isolation and back-to-back start from DONE.
        start_op(14, 3);
        check("b2b_busy0", int'(busy), 1);
        dividend = 4'd7;
        divisor  = 2'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'd5;
        divisor  = 2'd1;
        wait_done("b2b_first", edges, bc);
        check("b2b_first_lat", edges + 1, DW);
        check("b2b_first_q", int'(quotient), 4);
        check("b2b_first_r", int'(remainder), 2);
        start_op(7, 2);
        check("b2b_done_drop", int'(done), 0);
        check("b2b_busy_again", int'(busy), 1);
        check("b2b_hold_q", int'(quotient), 4);
        wait_done("b2b_second", edges, bc);
        check("b2b_second_lat", edges, DW);
        check("b2b_second_q", int'(quotient), 3);
        check("b2b_second_r", int'(remainder), 1);
        @(posedge clk);
        #1;
        check("b2b_second_pulse", int'(done), 0);

        // Reset abort in the second RUN cycle.
        start_op(13, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_q", int'(quotient), 0);
        check("abort_r", int'(remainder), 0);
        check("abort_z", int'(div_by_zero), 0);
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                if (done || busy) seen++;
                @(posedge clk);
                #1;
            end
            check("abort_no_done", seen, 0);
        end
        run_op("after_abort", 13, 2, 6, 1, 0);

        // Random operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            int a, b;
            a = int'($urandom_range(0, (1 << DW) - 1));
            b = int'($urandom_range(0, (1 << SW) - 1));
            model(a, b, eq, er, ez);
            run_op($sformatf("rnd%0d_%0d_%0d", n, a, b), a, b, eq, er, ez);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
